dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//   Shares the single-port Data_RAM between two requesters: port 0 = core load/store
//   path, port 1 = debug/loader. Per-port valid/ready handshake; one RAM op per cycle.
//   Round-robin arbitration with a bounded burst hold. Registered 1-cycle response.
//   Sits between the core memory-access stage, the debug port and Data_RAM.
// PARAMETERS
//   ADDR_W     16  RAM word-address width (matches ram_a)
//   DATA_W     32  data width
//   MAX_BURST  4   max consecutive grants to one port while the other waits (>=1)
// PORTS
//   clk          in   1       clock
//   rst          in   1       synchronous, active-high reset
//   req_valid    in   2       request valid, [0]=core, [1]=debug
//   req_ready    out  2       request accepted this cycle when valid&ready
//   req_we       in   2       1 = write, 0 = read
//   req_addr     in   2xADDR_W  word address per port
//   req_wdata    in   2xDATA_W  write data per port
//   rsp_valid    out  2       response pulse, 1 cycle after acceptance
//   rsp_rdata    out  DATA_W  read data (shared; qualified by rsp_valid)
//   ram_a        out  ADDR_W  to Data_RAM a
//   ram_d        out  DATA_W  to Data_RAM d
//   ram_we       out  1       to Data_RAM we
//   ram_spo      in   DATA_W  Data_RAM asynchronous read data
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0 (core favoured), burst_cnt=0, rsp_valid=0,
//   rsp_rdata=0. Combinational outputs with no valid: req_ready=0, ram_we=0,
//   ram_a=0, ram_d=0. In-flight response at reset is dropped.
// - States: IDLE, OWN0, OWN1 (current owner). burst_cnt = grants to owner in a row.
// - Grant (combinational, this cycle), g in {none,0,1}:
//   * no valid -> none; exactly one valid -> that port.
//   * both valid, IDLE -> port rr_ptr.
//   * both valid, OWNx, burst_cnt < MAX_BURST -> x; burst_cnt == MAX_BURST -> other.
// - req_ready[g]=1 only for granted port; never both. No RAM backpressure.
// - RAM drive: ram_a/ram_d = granted port's addr/wdata; ram_we = granted & req_we[g].
//   Write takes effect at the clock edge (Data_RAM synchronous write).
// - Next state on clock edge:
//   * g=none -> IDLE, burst_cnt=0, rr_ptr unchanged.
//   * g=x and state==OWNx -> burst_cnt+1 (saturate at MAX_BURST).
//   * g=x otherwise -> OWNx, burst_cnt=1, rr_ptr = ~x.
// - Response: rsp_valid[g] <= 1 for the accepted op (read and write); others 0.
//   Reads: rsp_rdata <= ram_spo sampled in acceptance cycle. Writes: rsp_rdata <= 0.
//   Latency exactly 1 cycle; back-to-back acceptance gives back-to-back responses.
// - Read-after-write same address, consecutive cycles: read returns new data.
// - Same-cycle both valid never issues two RAM ops; loser keeps valid, holds payload.
// - MAX_BURST=1 degenerates to strict alternation when both contend.
// TESTING
//   1 Reset: rst=1 2 cycles, random inputs -> rsp_valid=0, ram_we=0 after release.
//   2 Core write 0x0010<=0xDEADBEEF then read 0x0010 -> rsp_valid[0] at +1 each;
//     read rsp_rdata=0xDEADBEEF.
//   3 Both valid from IDLE, reads -> port0 granted first, then port1 (rr_ptr flips).
//   4 Port0 holds valid 10 cycles, port1 valid from cycle 1, MAX_BURST=4 -> grants
//     0,0,0,0,1,0,0,0,0,1 (port1 dropped after served once, re-raised).
//   5 Port1 writes 0x0100<=0x12345678 while port0 stalled; then port0 reads 0x0100
//     -> 0x12345678; never req_ready=2'b11.
//   6 rst asserted in cycle after acceptance -> no rsp_valid, state IDLE.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of the single-port Data_RAM, with burst hold.
// Grant and RAM drive are combinational; the response is registered one cycle later.
module dram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   ram_a,
  output logic [DATA_W-1:0]   ram_d,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_spo
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             rr_ptr, rr_ptr_nxt;
  logic             gnt_vld;
  logic             gnt_port;
  logic [1:0]       rsp_valid_q;

  // Nothing is granted while in reset, so stray inputs cannot write the RAM.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 1'b0;
    if (!rst) begin
      case (req_valid)
        2'b01: begin
          gnt_vld  = 1'b1;
          gnt_port = 1'b0;
        end
        2'b10: begin
          gnt_vld  = 1'b1;
          gnt_port = 1'b1;
        end
        2'b11: begin
          gnt_vld = 1'b1;
          case (state)
            OWN0:    gnt_port = (burst_cnt < MAX_CNT) ? 1'b0 : 1'b1;
            OWN1:    gnt_port = (burst_cnt < MAX_CNT) ? 1'b1 : 1'b0;
            default: gnt_port = rr_ptr;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    rr_ptr_nxt    = rr_ptr;
    if (!gnt_vld) begin
      state_nxt     = IDLE;
      burst_cnt_nxt = '0;
    end else if ((gnt_port == 1'b0 && state == OWN0) || (gnt_port == 1'b1 && state == OWN1)) begin
      burst_cnt_nxt = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + ONE_CNT;
    end else begin
      state_nxt     = gnt_port ? OWN1 : OWN0;
      burst_cnt_nxt = ONE_CNT;
      rr_ptr_nxt    = ~gnt_port;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    ram_a     = '0;
    ram_d     = '0;
    ram_we    = 1'b0;
    if (gnt_vld) begin
      req_ready[gnt_port] = 1'b1;
      ram_a  = gnt_port ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
      ram_d  = gnt_port ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      ram_we = req_we[gnt_port];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 2'b00;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid_q <= gnt_vld ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;
      if (gnt_vld) begin
        rsp_rdata <= ram_we ? '0 : ram_spo;
      end
    end
  end

  // A response still pending when reset arrives is dropped, not presented.
  assign rsp_valid = rsp_valid_q & {2{~rst}};

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural Data_RAM (sync write, async read).
module tb_dram_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [15:0] ram_a;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_spo;

  int checks = 0;
  int errors = 0;

  bit [31:0] mem     [0:65535];
  bit        wr_mask [0:65535];

  dram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .ram_spo   (ram_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read back as a recognisable address-derived pattern.
  assign ram_spo = wr_mask[ram_a] ? mem[ram_a] : {16'hA5A5, ram_a};
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_a]     <= ram_d;
      wr_mask[ram_a] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic we,
                          input logic [15:0] a, input logic [31:0] d);
    req_valid[p]         = v;
    req_we[p]            = we;
    req_addr[p*16 +: 16] = a;
    req_wdata[p*32 +: 32] = d;
  endtask

  task automatic idle_inputs;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  logic [1:0] exp_gnt [0:9];

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset with random traffic on the request side
    for (int i = 0; i < 2; i++) begin
      #1;
      req_valid = 2'($urandom);
      req_we    = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom};
      #1;
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ready", req_ready, 2'b00);
      tick();
      chk("rst_rsp_valid", rsp_valid, 2'b00);
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 2'b00);
    chk("post_rst_ram_we", ram_we, 1'b0);
    chk("post_rst_ram_a", ram_a, 16'h0000);
    chk("post_rst_ram_d", ram_d, 32'h0);
    chk("post_rst_ready", req_ready, 2'b00);
    chk("post_rst_rdata", rsp_rdata, 32'h0);
    tick();

    // Both read from IDLE: core first, then debug
    set_port(0, 1'b1, 1'b0, 16'h0020, 32'h0);
    set_port(1, 1'b1, 1'b0, 16'h0030, 32'h0);
    #1;
    chk("rr_first_ready", req_ready, 2'b01);
    chk("rr_first_addr", ram_a, 16'h0020);
    tick();
    set_port(0, 1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("rr_first_rsp", rsp_valid, 2'b01);
    chk("rr_first_rdata", rsp_rdata, 32'hA5A50020);
    chk("rr_second_ready", req_ready, 2'b10);
    chk("rr_second_addr", ram_a, 16'h0030);
    tick();
    idle_inputs();
    #1;
    chk("rr_second_rsp", rsp_valid, 2'b10);
    chk("rr_second_rdata", rsp_rdata, 32'hA5A50030);
    tick();

    // Core write then read-back of the same word
    set_port(0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    #1;
    chk("wr_ready", req_ready, 2'b01);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_a", ram_a, 16'h0010);
    chk("wr_ram_d", ram_d, 32'hDEADBEEF);
    tick();
    set_port(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    #1;
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("rd_ram_we", ram_we, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();

    // Burst hold: core streams 10 cycles, debug contends and is cut in every 5th
    for (int i = 0; i < 10; i++) exp_gnt[i] = (i == 4 || i == 9) ? 2'b10 : 2'b01;
    for (int i = 0; i < 10; i++) begin
      set_port(0, 1'b1, 1'b0, 16'h0040, 32'h0);
      set_port(1, (i >= 1 && i <= 4) || i >= 6, 1'b0, 16'h0050, 32'h0);
      #1;
      chk($sformatf("burst_ready_%0d", i), req_ready, exp_gnt[i]);
      if (i > 0) chk($sformatf("burst_rsp_%0d", i), rsp_valid, exp_gnt[i-1]);
      tick();
    end
    idle_inputs();
    #1;
    chk("burst_last_rsp", rsp_valid, 2'b10);
    chk("burst_last_rdata", rsp_rdata, 32'hA5A50050);
    tick();

    // Debug owns the RAM and writes while the core waits, then core reads it back
    set_port(1, 1'b1, 1'b1, 16'h0104, 32'h0BADF00D);
    #1;
    chk("dbg_own_ready", req_ready, 2'b10);
    tick();
    set_port(1, 1'b1, 1'b1, 16'h0100, 32'h12345678);
    set_port(0, 1'b1, 1'b0, 16'h0100, 32'h0);
    #1;
    chk("dbg_wr_ready", req_ready, 2'b10);
    chk("dbg_wr_ram_we", ram_we, 1'b1);
    chk("dbg_wr_ram_a", ram_a, 16'h0100);
    tick();
    set_port(1, 1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("core_rd_ready", req_ready, 2'b01);
    chk("dbg_wr_rsp", rsp_valid, 2'b10);
    tick();
    idle_inputs();
    #1;
    chk("core_rd_rsp", rsp_valid, 2'b01);
    chk("core_rd_rdata", rsp_rdata, 32'h12345678);
    tick();

    // Reset right after an acceptance drops the response and returns to IDLE
    set_port(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    #1;
    chk("pre_rst_ready", req_ready, 2'b01);
    tick();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_drop_rsp", rsp_valid, 2'b00);
    tick();
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 16'h0020, 32'h0);
    set_port(1, 1'b1, 1'b0, 16'h0030, 32'h0);
    #1;
    chk("rst_idle_rsp", rsp_valid, 2'b00);
    chk("rst_idle_ready", req_ready, 2'b01);
    tick();
    idle_inputs();
    #1;
    chk("rst_idle_grant_rsp", rsp_valid, 2'b01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
